// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: one shared 32-step shift-add / restoring-divide
// datapath, start/done handshake, divide-by-zero and signed-overflow fast paths.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] ZERO     = '0;
  localparam logic [XLEN-1:0] ONES     = '1;
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic                sign_a_q, sign_a_d;
  logic                sign_b_q, sign_b_d;
  logic                nofix_q, nofix_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                done_q, done_d;

  // Operand conditioning at acceptance: signedness, magnitudes and fast-path detection
  logic            signed_a, signed_b, neg_a, neg_b;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div_zero, div_ovf;

  always_comb begin
    signed_a = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    signed_b = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    neg_a    = signed_a && a[XLEN-1];
    neg_b    = signed_b && b[XLEN-1];
    abs_a    = neg_a ? -a : a;
    abs_b    = neg_b ? -b : b;
    div_zero = op[2] && (b == ZERO);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (a == INT_MIN) && (b == ONES);
  end

  // One iteration of each algorithm; the 33-bit trial's MSB is the borrow
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {1'b0, ZERO});
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
    if (div_trial[XLEN]) begin
      div_next = {acc_q[2*XLEN-2:0], 1'b0};
    end else begin
      div_next = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
  end

  // Sign correction and result select; fast-path results are preloaded and bypass correction
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_result;

  always_comb begin
    prod_fix = acc_q;
    quot_fix = acc_q[XLEN-1:0];
    rem_fix  = acc_q[2*XLEN-1:XLEN];
    if (!nofix_q) begin
      if (sign_a_q ^ sign_b_q) begin
        prod_fix = -acc_q;
        quot_fix = -acc_q[XLEN-1:0];
      end
      if (sign_a_q) begin
        rem_fix = -acc_q[2*XLEN-1:XLEN];
      end
    end
    if (!op_q[2]) begin
      fix_result = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end else begin
      fix_result = op_q[1] ? rem_fix : quot_fix;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    nofix_d  = nofix_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          op_d     = op;
          sign_a_d = neg_a;
          sign_b_d = neg_b;
          cnt_d    = '0;
          nofix_d  = 1'b0;
          if (div_zero) begin
            acc_d   = {a, ONES};
            nofix_d = 1'b1;
            state_d = FIX;
          end else if (div_ovf) begin
            acc_d   = {ZERO, INT_MIN};
            nofix_d = 1'b1;
            state_d = FIX;
          end else if (op[2]) begin
            opnd_d  = abs_b;
            acc_d   = {ZERO, abs_a};
            state_d = CALC;
          end else begin
            opnd_d  = abs_a;
            acc_d   = {ZERO, abs_b};
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = FIX;
        end
      end
      FIX: begin
        result_d = fix_result;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A flush abandons whatever is in flight without touching the visible result
    if (kill) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      opnd_q   <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      nofix_q  <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      nofix_q  <= nofix_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed vectors push expected results and done times,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_seq;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] last_exp = '0;

  typedef struct {
    logic [31:0] res;
    int          due;
    string       name;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_t;

  muldiv_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic waitIdle();
    int g = 0;
    while (busy && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("[TB] FAIL idle_timeout actual=busy expected=idle");
    end
  endtask

  // Issue one op, record its expected result and done cycle; hold keeps start high with junk operands
  task automatic applyStimulus(input string name, input logic [2:0] o, input logic [31:0] x,
                               input logic [31:0] y, input logic [31:0] e, input int lat,
                               input bit hold, output int acc_cyc);
    waitIdle();
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    sbq.push_back('{res: e, due: cyc + lat, name: name});
    checkOutput({name, "_busy"}, {31'b0, busy}, 32'd1);
    if (hold) begin
      op = ~o;
      a  = ~x;
      b  = y + 32'd1;
      repeat (20) @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic startRaw(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int acc_cyc);
    waitIdle();
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done actual=done result=0x%08h expected=no done", result);
      end else begin
        mon_t = sbq.pop_front();
        checkOutput(mon_t.name, result, mon_t.res);
        checkOutput({mon_t.name, "_latency"}, 32'(cyc), 32'(mon_t.due));
        last_exp = mon_t.res;
      end
    end
  end

  initial begin
    int t0;
    int t1;
    int g;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus("mulh_m2_3",     MULH,   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 33, 1'b0, t0);
    applyStimulus("mulhu_max",     MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0, t0);
    applyStimulus("mulhsu_m1_max", MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1'b0, t0);
    applyStimulus("mul_7fff_2",    MUL,    32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 33, 1'b0, t0);
    applyStimulus("mul_0_5",       MUL,    32'd0,        32'd5,        32'd0,        33, 1'b0, t0);
    applyStimulus("div_m7_2",      DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 1'b0, t0);
    applyStimulus("rem_m7_2",      REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 1'b0, t0);
    applyStimulus("divu_7_2",      DIVU,   32'd7,        32'd2,        32'd3,        33, 1'b0, t0);
    applyStimulus("remu_7_2",      REMU,   32'd7,        32'd2,        32'd1,        33, 1'b0, t0);

    applyStimulus("divu_5_0",      DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1,  1'b0, t0);
    applyStimulus("rem_5_0",       REM,    32'd5,        32'd0,        32'd5,        1,  1'b0, t0);
    applyStimulus("div_m5_0",      DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1,  1'b0, t0);
    applyStimulus("rem_m5_0",      REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1,  1'b0, t0);
    applyStimulus("div_ovf",       DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1'b0, t0);
    applyStimulus("rem_ovf",       REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  1'b0, t0);

    applyStimulus("mul_hold_start", MUL,   32'd3,        32'd4,        32'd12,       33, 1'b1, t0);

    applyStimulus("div_100_7",     DIV,    32'd100,      32'd7,        32'd14,       33, 1'b0, t0);
    applyStimulus("rem_100_7",     REM,    32'd100,      32'd7,        32'd2,        33, 1'b0, t1);
    checkOutput("b2b_accept_cycle", 32'(t1), 32'(t0 + 34));

    startRaw(MUL, 32'd3, 32'd4, t0);
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    checkOutput("kill_busy", {31'b0, busy}, 32'd0);
    checkOutput("kill_done", {31'b0, done}, 32'd0);
    checkOutput("kill_result_kept", result, last_exp);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("kill_still_idle", {31'b0, busy}, 32'd0);

    op    = MULHU;
    a     = 32'd1;
    b     = 32'd1;
    start = 1'b1;
    kill  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    kill  = 1'b0;
    checkOutput("kill_start_busy", {31'b0, busy}, 32'd0);
    repeat (40) @(posedge clk);
    #1;

    startRaw(DIVU, 32'd100, 32'd7, t0);
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midop_reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("midop_reset_done", {31'b0, done}, 32'd0);
    checkOutput("midop_reset_result", result, 32'd0);
    rst_n = 1'b1;
    last_exp = '0;
    repeat (40) @(posedge clk);
    #1;

    applyStimulus("divu_after_reset", DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0, t0);

    g = 0;
    while (sbq.size() != 0 && g < 100) begin
      @(posedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout actual=%0d pending expected=0 pending", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
